// File: rtl/usb_tx_packetizer_pkg.sv
// Shared USB transmit definitions: packet kinds, PID codes, SYNC pattern and CRC constants.
package usb_tx_packetizer_pkg;

    typedef enum logic [1:0] {
        PK_TOKEN     = 2'd0,
        PK_DATA      = 2'd1,
        PK_HANDSHAKE = 2'd2
    } usb_pkt_kind_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    // Indexed by bit position in transmit order: seven zeros then a one.
    localparam logic [7:0]  SYNC_PATTERN  = 8'b1000_0000;
    localparam logic [4:0]  CRC5_POLY     = 5'b00101;
    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

    // The reserved encoding is sent as a handshake.
    function automatic logic [1:0] normalize_kind(input logic [1:0] kind);
        return (kind == 2'b11) ? PK_HANDSHAKE : kind;
    endfunction

endpackage

// File: rtl/usb_tx_packetizer_crc.sv
// Bit-serial CRC register, MSB-first feedback, preset to all ones.
module usb_crc_serial #(
    parameter int                 WIDTH = 5,
    parameter logic [WIDTH-1:0]   POLY  = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             init,
    input  logic             enable,
    input  logic             bit_in,
    output logic [WIDTH-1:0] crc
);

    logic [WIDTH-1:0] r_crc;
    logic             w_fb;

    assign w_fb = bit_in ^ r_crc[WIDTH-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_crc <= '1;
        end else if (init) begin
            r_crc <= '1;
        end else if (enable) begin
            r_crc <= {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/usb_tx_packetizer.sv
// Host transmit serializer: SYNC, PID, token/data fields, CRC, then a 2-cycle EOP request.
module usb_tx_packetizer
    import usb_tx_packetizer_pkg::*;
#(
    parameter int DATA_BYTES = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [1:0]              pkt_kind,
    input  logic [3:0]              pid,
    input  logic [6:0]              addr,
    input  logic [3:0]              endp,
    input  logic [8*DATA_BYTES-1:0] payload,
    input  logic                    pause,
    output logic                    stream,
    output logic                    stream_valid,
    output logic                    eop,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = $clog2(DATA_BYTES + 1);
    localparam int PW = 8 * DATA_BYTES;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_PID   = 3'd2;
    localparam logic [2:0] ST_TOKEN = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_CRC   = 3'd5;
    localparam logic [2:0] ST_EOP   = 3'd6;

    logic [2:0]    r_state;
    logic [2:0]    r_bit_idx;
    logic [CW-1:0] r_byte_cnt;
    logic [1:0]    r_kind;
    logic [7:0]    r_pid_byte;
    logic [PW-1:0] r_shift;
    logic          r_eop_cnt;
    logic          r_done;

    logic          w_start;
    logic          w_valid;
    logic          w_adv;
    logic          w_last;
    logic [2:0]    w_next_state;
    logic          w_stream;
    logic [3:0]    w_crc16_idx;
    logic [4:0]    w_crc5;
    logic [15:0]   w_crc16;
    logic [1:0]    w_kind_in;

    assign w_kind_in = normalize_kind(pkt_kind);
    // The done cycle is already IDLE, so r_done blocks a start arriving on it.
    assign w_start   = start && (r_state == ST_IDLE) && !r_done;
    assign w_valid   = (r_state == ST_SYNC) || (r_state == ST_PID) || (r_state == ST_TOKEN) ||
                       (r_state == ST_DATA) || (r_state == ST_CRC);
    assign w_adv     = w_valid && !pause;
    assign w_crc16_idx = {r_byte_cnt[0], r_bit_idx};

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            ST_SYNC, ST_PID: w_last = (r_bit_idx == 3'd7);
            ST_TOKEN:        w_last = (r_byte_cnt == CW'(1)) && (r_bit_idx == 3'd2);
            ST_DATA:         w_last = (r_byte_cnt == CW'(DATA_BYTES - 1)) && (r_bit_idx == 3'd7);
            ST_CRC:          w_last = (r_kind == PK_TOKEN) ? (r_bit_idx == 3'd4)
                                    : ((r_byte_cnt == CW'(1)) && (r_bit_idx == 3'd7));
            default:         w_last = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_SYNC:  w_next_state = ST_PID;
            ST_PID:   w_next_state = (r_kind == PK_TOKEN) ? ST_TOKEN
                                   : (r_kind == PK_DATA)  ? ST_DATA : ST_EOP;
            ST_TOKEN: w_next_state = ST_CRC;
            ST_DATA:  w_next_state = ST_CRC;
            ST_CRC:   w_next_state = ST_EOP;
            default:  w_next_state = r_state;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_bit_idx  <= '0;
            r_byte_cnt <= '0;
            r_kind     <= '0;
            r_pid_byte <= '0;
            r_shift    <= '0;
            r_eop_cnt  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_state    <= ST_SYNC;
                r_bit_idx  <= '0;
                r_byte_cnt <= '0;
                r_kind     <= w_kind_in;
                r_pid_byte <= {~pid, pid};
                r_shift    <= (w_kind_in == PK_TOKEN) ? PW'({endp, addr}) : payload;
                r_eop_cnt  <= 1'b0;
            end else if (w_adv) begin
                if ((r_state == ST_TOKEN) || (r_state == ST_DATA)) begin
                    r_shift <= r_shift >> 1;
                end
                if (w_last) begin
                    r_state    <= w_next_state;
                    r_bit_idx  <= '0;
                    r_byte_cnt <= '0;
                end else begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        r_byte_cnt <= r_byte_cnt + CW'(1);
                    end
                end
            end else if (r_state == ST_EOP) begin
                // Only the first EOP cycle waits out a trailing stuff bit.
                if (r_eop_cnt) begin
                    r_state   <= ST_IDLE;
                    r_eop_cnt <= 1'b0;
                    r_done    <= 1'b1;
                end else if (!pause) begin
                    r_eop_cnt <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_stream = 1'b0;
        case (r_state)
            ST_SYNC:           w_stream = SYNC_PATTERN[r_bit_idx];
            ST_PID:            w_stream = r_pid_byte[r_bit_idx];
            ST_TOKEN, ST_DATA: w_stream = r_shift[0];
            ST_CRC:            w_stream = (r_kind == PK_TOKEN) ? ~w_crc5[3'd4 - r_bit_idx]
                                                               : ~w_crc16[4'd15 - w_crc16_idx];
            default:           w_stream = 1'b0;
        endcase
    end

    usb_crc_serial #(
        .WIDTH (5),
        .POLY  (CRC5_POLY)
    ) u_crc5 (
        .clock   (clock),
        .reset_n (reset_n),
        .init    (w_start),
        .enable  (w_adv && (r_state == ST_TOKEN)),
        .bit_in  (r_shift[0]),
        .crc     (w_crc5)
    );

    usb_crc_serial #(
        .WIDTH (16),
        .POLY  (CRC16_POLY)
    ) u_crc16 (
        .clock   (clock),
        .reset_n (reset_n),
        .init    (w_start),
        .enable  (w_adv && (r_state == ST_DATA)),
        .bit_in  (r_shift[0]),
        .crc     (w_crc16)
    );

    assign stream       = w_stream;
    assign stream_valid = w_valid;
    assign eop          = (r_state == ST_EOP) && (r_eop_cnt || !pause);
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;

endmodule
